// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_cmd_pkg : shared states, command/reply codes, frame length   |
// | Rev 1.0      : optional UART_CMD_CHECKSUM_EN adds a frame XOR byte|
// +------------------------------------------------------------------+
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RX_CMD   = 4'd1,
    ST_RX_ARG   = 4'd2,
    ST_DECODE   = 4'd3,
    ST_CFG      = 4'd4,
    ST_GEN      = 4'd5,
    ST_RESP     = 4'd6,
    ST_GEN_WAIT = 4'd7,
    ST_GEN_TX   = 4'd8,
    ST_TX_CHK   = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_ACK  = 2'd2,
    TX_DONE = 2'd3
  } tx_state_e;

  localparam logic [7:0] CMD_GEN  = 8'h01;
  localparam logic [7:0] CMD_CFG  = 8'h02;
  localparam logic [7:0] CMD_PING = 8'h03;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_PING = 8'h5A;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

`ifdef UART_CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  // Index of the last byte collected in RX_ARG (sync and cmd excluded)
  localparam logic [2:0] ARG_LAST_IDX = 3'(FRAME_LEN - 3);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_seq : one-byte transmit handshake with re-pulse on no ack |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module uart_tx_seq
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic [7:0] tx_data,
  output logic       tx_data_en,
  input  logic       tx_busy
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] retry_q, retry_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      data_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    retry_d    = retry_q;
    tx_data_en = 1'b0;
    byte_done  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (byte_valid) begin
          data_d  = byte_data;
          state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        if (!tx_busy) begin
          tx_data_en = 1'b1;
          retry_d    = '0;
          state_d    = TX_ACK;
        end
      end
      TX_ACK: begin
        // Eight cycles without busy means the launch was missed: pulse again
        if (tx_busy)               state_d = TX_DONE;
        else if (retry_q == 3'd7)  state_d = TX_LOAD;
        else                       retry_d = retry_q + 3'd1;
      end
      TX_DONE: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
          state_d   = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_data = data_q;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_cmd_ctrl : host frame parser, config/generator control and   |
// | word serializer. Option macro: UART_CMD_CHECKSUM_EN. Rev 1.0      |
// +------------------------------------------------------------------+
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         WORD_BYTES  = 16,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_en,
  output logic [7:0]              tx_data,
  output logic                    tx_data_en,
  input  logic                    tx_busy,
  output logic                    gen_start,
  output logic [31:0]             gen_count,
  input  logic                    gen_valid,
  input  logic [8*WORD_BYTES-1:0] gen_data,
  output logic                    gen_ready,
  output logic                    cfg_we,
  output logic [31:0]             cfg_data,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam int              BI_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BI_W-1:0] BYTE_LAST = BI_W'(WORD_BYTES - 1);
  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [31:0]             arg_q, arg_d;
  logic [2:0]              arg_idx_q, arg_idx_d;
  logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [31:0]             cfg_data_q, cfg_data_d;
  logic [31:0]             gen_count_q, gen_count_d;
  logic [31:0]             word_cnt_q, word_cnt_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [BI_W-1:0]         byte_idx_q, byte_idx_d;
  logic [7:0]              reply_q, reply_d;

  logic       err_inc;
  logic       frame_ok;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       byte_done;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] rx_chk_q, rx_chk_d;
  logic       chk_ok_q, chk_ok_d;
  logic [7:0] tx_xor_q, tx_xor_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_chk_q <= '0;
      chk_ok_q <= 1'b0;
      tx_xor_q <= '0;
    end else begin
      rx_chk_q <= rx_chk_d;
      chk_ok_q <= chk_ok_d;
      tx_xor_q <= tx_xor_d;
    end
  end

  assign frame_ok = chk_ok_q;
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      arg_q       <= '0;
      arg_idx_q   <= '0;
      tmo_cnt_q   <= '0;
      err_cnt_q   <= '0;
      cfg_data_q  <= '0;
      gen_count_q <= '0;
      word_cnt_q  <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      reply_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      arg_idx_q   <= arg_idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_cnt_q   <= err_cnt_d;
      cfg_data_q  <= cfg_data_d;
      gen_count_q <= gen_count_d;
      word_cnt_q  <= word_cnt_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      reply_q     <= reply_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    arg_idx_d   = arg_idx_q;
    tmo_cnt_d   = tmo_cnt_q;
    cfg_data_d  = cfg_data_q;
    gen_count_d = gen_count_q;
    word_cnt_d  = word_cnt_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    reply_d     = reply_q;
`ifdef UART_CMD_CHECKSUM_EN
    rx_chk_d    = rx_chk_q;
    chk_ok_d    = chk_ok_q;
    tx_xor_d    = tx_xor_q;
`endif
    err_inc     = 1'b0;
    gen_start   = 1'b0;
    gen_ready   = 1'b0;
    cfg_we      = 1'b0;
    byte_valid  = 1'b0;
    byte_out    = reply_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_data_en && (rx_data == SYNC_BYTE)) begin
          tmo_cnt_d = '0;
          state_d   = ST_RX_CMD;
        end
      end

      ST_RX_CMD, ST_RX_ARG: begin
        if (rx_data_en) begin
          tmo_cnt_d = '0;
          if (state_q == ST_RX_CMD) begin
            cmd_d     = rx_data;
            arg_idx_d = '0;
            state_d   = ST_RX_ARG;
`ifdef UART_CMD_CHECKSUM_EN
            rx_chk_d  = rx_data;
`endif
          end else begin
`ifdef UART_CMD_CHECKSUM_EN
            if (arg_idx_q == ARG_LAST_IDX) begin
              chk_ok_d = (rx_chk_q == rx_data);
            end else begin
              arg_d[8*arg_idx_q[1:0] +: 8] = rx_data;
              rx_chk_d = rx_chk_q ^ rx_data;
            end
`else
            arg_d[8*arg_idx_q[1:0] +: 8] = rx_data;
`endif
            arg_idx_d = arg_idx_q + 3'd1;
            if (arg_idx_q == ARG_LAST_IDX) state_d = ST_DECODE;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_DECODE: begin
        reply_d = RSP_ERR;
        state_d = ST_RESP;
        if (!frame_ok) begin
          err_inc = 1'b1;
        end else begin
          case (cmd_q)
            CMD_GEN: begin
              if (arg_q == 32'd0) begin
                err_inc = 1'b1;
              end else begin
                gen_count_d = arg_q;
                word_cnt_d  = arg_q;
                state_d     = ST_GEN;
              end
            end
            CMD_CFG: begin
              cfg_data_d = arg_q;
              state_d    = ST_CFG;
            end
            CMD_PING: reply_d = RSP_PING;
            default:  err_inc = 1'b1;
          endcase
        end
      end

      ST_CFG: begin
        cfg_we  = 1'b1;
        reply_d = RSP_ACK;
        state_d = ST_RESP;
      end

      ST_GEN: begin
        gen_start = 1'b1;
        state_d   = ST_GEN_WAIT;
      end

      ST_GEN_WAIT: begin
        // Ready follows valid so the handshake is a single cycle
        gen_ready = gen_valid;
        if (gen_valid) begin
          word_d     = gen_data;
          word_cnt_d = word_cnt_q - 32'd1;
          byte_idx_d = '0;
          state_d    = ST_GEN_TX;
`ifdef UART_CMD_CHECKSUM_EN
          tx_xor_d   = '0;
`endif
        end
      end

      ST_GEN_TX: begin
        byte_valid = 1'b1;
        byte_out   = word_q[8*byte_idx_q +: 8];
        if (byte_done) begin
`ifdef UART_CMD_CHECKSUM_EN
          tx_xor_d = tx_xor_q ^ byte_out;
`endif
          if (byte_idx_q == BYTE_LAST) begin
            byte_idx_d = '0;
`ifdef UART_CMD_CHECKSUM_EN
            state_d    = ST_TX_CHK;
`else
            state_d    = (word_cnt_q == 32'd0) ? ST_IDLE : ST_GEN_WAIT;
`endif
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end

      ST_RESP: begin
        byte_valid = 1'b1;
        if (byte_done) begin
`ifdef UART_CMD_CHECKSUM_EN
          tx_xor_d = reply_q;
          state_d  = ST_TX_CHK;
`else
          state_d  = ST_IDLE;
`endif
        end
      end

      ST_TX_CHK: begin
`ifdef UART_CMD_CHECKSUM_EN
        byte_valid = 1'b1;
        byte_out   = tx_xor_q;
`endif
        if (byte_done) state_d = (word_cnt_q == 32'd0) ? ST_IDLE : ST_GEN_WAIT;
      end

      default: state_d = ST_IDLE;
    endcase

    err_cnt_d = err_inc ? sat_inc8(err_cnt_q) : err_cnt_q;
  end

  uart_tx_seq u_tx_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_out),
    .byte_done  (byte_done),
    .tx_data    (tx_data),
    .tx_data_en (tx_data_en),
    .tx_busy    (tx_busy)
  );

  assign gen_count = gen_count_q;
  assign cfg_data  = cfg_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_cmd_ctrl : directed bench with transceiver/generator models|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_uart_cmd_ctrl;

  localparam int WB       = 4;
  localparam int BUSY_CYC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_data_en;
  logic [7:0]    tx_data;
  logic          tx_data_en;
  logic          tx_busy = 1'b0;
  logic          gen_start;
  logic [31:0]   gen_count;
  logic          gen_valid;
  logic [8*WB-1:0] gen_data;
  logic          gen_ready;
  logic          cfg_we;
  logic [31:0]   cfg_data;
  logic          busy;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .WORD_BYTES  (WB),
    .TIMEOUT_CYC (100),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_data_en (rx_data_en),
    .tx_data    (tx_data),
    .tx_data_en (tx_data_en),
    .tx_busy    (tx_busy),
    .gen_start  (gen_start),
    .gen_count  (gen_count),
    .gen_valid  (gen_valid),
    .gen_data   (gen_data),
    .gen_ready  (gen_ready),
    .cfg_we     (cfg_we),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  // Transceiver model: launch on rising tx_data_en, busy for BUSY_CYC cycles
  logic [7:0] cap_mem [256];
  int         cap_wr    = 0;
  int         en_pulses = 0;
  int         viol      = 0;
  int         drop_req  = 0;
  int         drop_done = 0;
  int         busy_cnt  = 0;
  logic       en_prev   = 1'b0;

  always @(posedge clk) begin
    en_prev <= tx_data_en;
    if (!rst_n) begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end else if (tx_data_en && !en_prev) begin
      en_pulses <= en_pulses + 1;
      if (tx_busy) viol <= viol + 1;
      if (drop_req != drop_done) begin
        drop_done <= drop_done + 1;
      end else begin
        cap_mem[cap_wr[7:0]] <= tx_data;
        cap_wr   <= cap_wr + 1;
        tx_busy  <= 1'b1;
        busy_cnt <= BUSY_CYC;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  // Generator model plus strobe monitors
  logic [8*WB-1:0] gen_words [4];
  int          gen_avail  = 0;
  int          gen_idx    = 0;
  int          start_cnt  = 0;
  int          ready_cyc  = 0;
  int          cfg_cnt    = 0;
  logic [31:0] gcount_cap = '0;
  logic [31:0] cfg_cap    = '0;

  assign gen_valid = (gen_idx < gen_avail);
  assign gen_data  = gen_valid ? gen_words[gen_idx[1:0]] : '0;

  always @(posedge clk) begin
    if (gen_start) begin
      gen_idx    <= 0;
      start_cnt  <= start_cnt + 1;
      gcount_cap <= gen_count;
    end else if (gen_valid && gen_ready) begin
      gen_idx <= gen_idx + 1;
    end
    if (gen_ready) ready_cyc <= ready_cyc + 1;
    if (cfg_we) begin
      cfg_cnt <= cfg_cnt + 1;
      cfg_cap <= cfg_data;
    end
  end

  // Scoreboard and counters
  logic [7:0] exp_q [$];
  int         cap_rd = 0;
  int         total  = 0;
  int         bad    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data    = b;
    rx_data_en = 1'b1;
    tick();
    rx_data_en = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] arg);
    send_byte(8'hA5);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(arg[8*i +: 8]);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cmd ^ arg[7:0] ^ arg[15:8] ^ arg[23:16] ^ arg[31:24]);
`endif
  endtask

  task automatic push_reply(input logic [7:0] r);
    exp_q.push_back(r);
`ifdef UART_CMD_CHECKSUM_EN
    exp_q.push_back(r);
`endif
  endtask

  task automatic push_word(input logic [8*WB-1:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < WB; i++) begin
      exp_q.push_back(w[8*i +: 8]);
      x = x ^ w[8*i +: 8];
    end
`ifdef UART_CMD_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || tx_busy) && n < 3000);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_tx(input string tag);
    int ne;
    logic [7:0] e;
    ne = exp_q.size();
    check({tag, "_nbytes"}, cap_wr - cap_rd, ne);
    for (int i = 0; i < ne; i++) begin
      e = exp_q.pop_front();
      if (cap_rd < cap_wr) begin
        check(tag, {24'd0, cap_mem[cap_rd[7:0]]}, {24'd0, e});
        cap_rd++;
      end
    end
    cap_rd = cap_wr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, c0, p0, base;
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_data_en = 1'b0;
    repeat (4) tick();
    check("rst_tx_en",   {31'd0, tx_data_en}, 32'd0);
    check("rst_busy",    {31'd0, busy},       32'd0);
    check("rst_err",     {24'd0, err_cnt},    32'd0);
    check("rst_strobes", {29'd0, gen_start, cfg_we, gen_ready}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data},    32'd0);
    check("rst_words",   gen_count | cfg_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // PING
    push_reply(8'h5A);
    send_frame(8'h03, 32'h0);
    wait_idle("ping");
    check_tx("ping_tx");
    check("ping_err", {24'd0, err_cnt}, 32'd0);

    // CFG
    c0 = cfg_cnt;
    push_reply(8'h06);
    send_frame(8'h02, 32'h12345678);
    wait_idle("cfg");
    check_tx("cfg_tx");
    check("cfg_we_cnt",  cfg_cnt - c0, 32'd1);
    check("cfg_cap",     cfg_cap,      32'h12345678);
    check("cfg_hold",    cfg_data,     32'h12345678);

    // GEN, two words
    gen_words[0] = 32'hDDCCBBAA;
    gen_words[1] = 32'h44332211;
    gen_avail    = 2;
    s0 = start_cnt;
    r0 = ready_cyc;
    push_word(32'hDDCCBBAA);
    push_word(32'h44332211);
    send_frame(8'h01, 32'd2);
    wait_idle("gen");
    check_tx("gen_tx");
    check("gen_start_cnt", start_cnt - s0, 32'd1);
    check("gen_count",     gcount_cap,     32'd2);
    check("gen_ready_cyc", ready_cyc - r0, 32'd2);
    check("tx_en_vs_busy", viol,           32'd0);
    check("gen_err",       {24'd0, err_cnt}, 32'd0);

    // Unknown command and GEN with zero count
    s0 = start_cnt;
    push_reply(8'hEE);
    send_frame(8'h7F, 32'h0);
    wait_idle("unk");
    push_reply(8'hEE);
    send_frame(8'h01, 32'h0);
    wait_idle("gen0");
    check_tx("err_tx");
    check("gen0_no_start", start_cnt - s0, 32'd0);
    check("err_cnt2",      {24'd0, err_cnt}, 32'd2);

    // Timeout after a partial frame
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (98) tick();
    check("tmo_before", {31'd0, busy}, 32'd1);
    tick();
    check("tmo_after",  {31'd0, busy}, 32'd0);
    check("tmo_err",    {24'd0, err_cnt}, 32'd3);
    check_tx("tmo_tx");
    push_reply(8'h5A);
    send_frame(8'h03, 32'h0);
    wait_idle("ping2");
    check_tx("ping2_tx");

    // Missed launch: the first tx_data_en is ignored by the transceiver
    p0 = en_pulses;
    drop_req = drop_req + 1;
    push_reply(8'h5A);
    send_frame(8'h03, 32'h0);
    wait_idle("retry");
    check_tx("retry_tx");
    check("retry_pulses", en_pulses - p0, (drop_req == drop_done) ? 32'd2 : 32'd0);
    check("retry_drop",   drop_done, drop_req);

    // Reset after two bytes of a word
    gen_words[0] = 32'h87654321;
    gen_avail    = 1;
    base = cap_wr;
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h43);
    send_frame(8'h01, 32'd1);
    for (int i = 0; i < 2000 && (cap_wr - base) < 2; i++) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_tx_en", {31'd0, tx_data_en}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},       32'd0);
    check("mid_rst_err",   {24'd0, err_cnt},    32'd0);
    rst_n = 1'b1;
    repeat (60) tick();
    check("mid_rst_tx_en2", {31'd0, tx_data_en}, 32'd0);
    check_tx("mid_rst_tx");
    push_reply(8'h5A);
    send_frame(8'h03, 32'h0);
    wait_idle("ping3");
    check_tx("ping3_tx");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
